// File: rtl/mult_pkg.sv
// Shared definitions for the repeated-addition multiplier: default widths and
// the controller state encoding.
package mult_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int PROD_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Product width that guarantees A*N never overflows.
  function automatic int prod_width(input int data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/repadd_mult_ctrl_if.sv
// Bundle of host handshake and down-counter strobes seen by the multiplier
// controller. The controller uses the slave view; host/counter side uses master.
interface repadd_mult_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int PROD_W = 32
);

  logic              start;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] cnt;
  logic              ld_N;
  logic              dec_N;
  logic [PROD_W-1:0] P;
  logic              busy;
  logic              done;

  modport slave (
    input  start,
    input  A,
    input  cnt,
    output ld_N,
    output dec_N,
    output P,
    output busy,
    output done
  );

  modport master (
    output start,
    output A,
    output cnt,
    input  ld_N,
    input  dec_N,
    input  P,
    input  busy,
    input  done
  );

endinterface

// File: rtl/repadd_mult_ctrl_prod_acc.sv
// Product accumulator: synchronous clear, add of a zero-extended addend, or hold.
module prod_acc #(
  parameter int DATA_W = 16,
  parameter int PROD_W = 32
) (
  input  logic              clk,
  input  logic              clr_i,
  input  logic              add_i,
  input  logic [DATA_W-1:0] addend_i,
  output logic [PROD_W-1:0] p_o
);

  logic [PROD_W-1:0] p_q;
  logic [PROD_W-1:0] p_d;
  logic [PROD_W-1:0] addend_ext;

  assign addend_ext = {{(PROD_W-DATA_W){1'b0}}, addend_i};

  always_comb begin
    p_d = p_q;
    if (clr_i) begin
      p_d = '0;
    end else if (add_i) begin
      p_d = p_q + addend_ext;
    end
  end

  always_ff @(posedge clk) begin
    p_q <= p_d;
  end

  assign p_o = p_q;

endmodule

// File: rtl/repadd_mult_ctrl.sv
// Repeated-addition multiplier controller: sequences the external down-counter
// and accumulates the latched multiplicand once per count.
module repadd_mult_ctrl
  import mult_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PROD_W = PROD_W_DEF
) (
  input logic                clk,
  input logic                clr,
  repadd_mult_ctrl_if.slave  bus
);

  state_e            state_q;
  state_e            state_d;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] a_d;
  logic              cnt_zero;
  logic              ld_n;
  logic              dec_n;
  logic              busy;
  logic              done;

  assign cnt_zero = (bus.cnt == '0);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    ld_n    = 1'b0;
    dec_n   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        busy    = 1'b1;
        ld_n    = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        // Counter output is registered, so decoding it here forms no loop.
        if (!cnt_zero) begin
          dec_n = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
    end
  end

  // LOAD clears the product so a fresh run never inherits the previous result.
  prod_acc #(
    .DATA_W (DATA_W),
    .PROD_W (PROD_W)
  ) u_prod_acc (
    .clk      (clk),
    .clr_i    (clr | ld_n),
    .add_i    (dec_n),
    .addend_i (a_q),
    .p_o      (bus.P)
  );

  assign bus.ld_N  = ld_n;
  assign bus.dec_N = dec_n;
  assign bus.busy  = busy;
  assign bus.done  = done;

endmodule

// File: tb/tb_repadd_mult_ctrl.sv
// Directed bench: controller closed around a behavioural 16-bit load/decrement
// down-counter, with cycle-accurate checks of strobes, handshake and product.
module tb_repadd_mult_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] n_host;
  logic [15:0] cnt_q;

  always #5 clk = ~clk;

  repadd_mult_ctrl_if #(.DATA_W(16), .PROD_W(32)) bus ();

  repadd_mult_ctrl #(.DATA_W(16), .PROD_W(32)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // Down-counter sharing the same clr as the controller.
  always_ff @(posedge clk) begin
    if (clr)             cnt_q <= 16'd0;
    else if (bus.ld_N)   cnt_q <= n_host;
    else if (bus.dec_N)  cnt_q <= cnt_q - 16'd1;
  end
  assign bus.cnt = cnt_q;

  int checks = 0;
  int passes = 0;

  int cyc;
  int ld_cnt, ld_first, ld_last;
  int dec_cnt, dec_first, dec_last;
  int done_cnt, done_cyc;
  int busy_first, busy_drop;
  int overlap;
  logic [31:0] p_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_stats();
    ld_cnt = 0; ld_first = -1; ld_last = -1;
    dec_cnt = 0; dec_first = -1; dec_last = -1;
    done_cnt = 0; done_cyc = -1; p_done = 32'hDEAD_BEEF;
    busy_first = -1; busy_drop = -1; overlap = 0;
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.ld_N) begin
      ld_cnt++;
      if (ld_first < 0) ld_first = cyc;
      ld_last = cyc;
    end
    if (bus.dec_N) begin
      dec_cnt++;
      if (dec_first < 0) dec_first = cyc;
      dec_last = cyc;
    end
    if (bus.ld_N && bus.dec_N) overlap++;
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
      p_done = bus.P;
    end
    if (bus.busy && busy_first < 0) busy_first = cyc;
    if (!bus.busy && busy_first >= 0 && busy_drop < 0) busy_drop = cyc;
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] n);
    bus.A = a;
    n_host = n;
    bus.start = 1'b1;
    clear_stats();
    cyc = 0;
    step();
  endtask

  task automatic run_to(input int last);
    while (cyc < last) step();
  endtask

  initial begin
    clr = 1'b1;
    bus.start = 1'b1;
    bus.A = 16'h0005;
    n_host = 16'd3;
    cyc = 0;
    clear_stats();

    // Reset held two cycles with start asserted: clr must win.
    step();
    step();
    check("rst_P", bus.P, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_ld", {31'd0, bus.ld_N}, 32'd0);
    check("rst_dec", {31'd0, bus.dec_N}, 32'd0);
    check("rst_ld_seen", ld_cnt, 32'd0);
    clr = 1'b0;
    bus.start = 1'b0;
    step();
    $display("txn reset: P=%0h busy=%0b", bus.P, bus.busy);

    // A=7, N=5
    launch(16'd7, 16'd5);
    bus.start = 1'b0;
    run_to(12);
    check("t1_ld_first", ld_first, 32'd1);
    check("t1_ld_cnt", ld_cnt, 32'd1);
    check("t1_dec_cnt", dec_cnt, 32'd5);
    check("t1_dec_first", dec_first, 32'd2);
    check("t1_dec_last", dec_last, 32'd6);
    check("t1_done_cyc", done_cyc, 32'd8);
    check("t1_done_cnt", done_cnt, 32'd1);
    check("t1_P_done", p_done, 32'd35);
    check("t1_busy_first", busy_first, 32'd1);
    check("t1_busy_drop", busy_drop, 32'd9);
    check("t1_overlap", overlap, 32'd0);
    check("t1_P_hold", bus.P, 32'd35);
    $display("txn A=7 N=5: done@%0d P=%0d", done_cyc, p_done);

    // A=0xFFFF, N=0
    launch(16'hFFFF, 16'd0);
    bus.start = 1'b0;
    run_to(6);
    check("t2_done_cyc", done_cyc, 32'd3);
    check("t2_P_done", p_done, 32'd0);
    check("t2_dec_cnt", dec_cnt, 32'd0);
    check("t2_done_cnt", done_cnt, 32'd1);
    $display("txn A=ffff N=0: done@%0d P=%0h", done_cyc, p_done);

    // A=0xFFFF, N=0xFFFF
    launch(16'hFFFF, 16'hFFFF);
    bus.start = 1'b0;
    run_to(65542);
    check("t3_done_cyc", done_cyc, 32'd65538);
    check("t3_P_done", p_done, 32'hFFFE_0001);
    check("t3_dec_cnt", dec_cnt, 32'd65535);
    check("t3_done_cnt", done_cnt, 32'd1);
    $display("txn A=ffff N=ffff: done@%0d P=%0h", done_cyc, p_done);

    // A=3, N=4, start held, A changed mid-run; a second run begins at cycle 8.
    launch(16'd3, 16'd4);
    run_to(3);
    bus.A = 16'd9;
    run_to(9);
    check("t4_done_cnt", done_cnt, 32'd1);
    check("t4_done_cyc", done_cyc, 32'd7);
    check("t4_P_done", p_done, 32'd12);
    check("t4_busy_drop", busy_drop, 32'd8);
    check("t4_ld_last", ld_last, 32'd9);
    check("t4_ld_cnt", ld_cnt, 32'd2);
    bus.start = 1'b0;
    run_to(17);
    check("t4_done_cnt2", done_cnt, 32'd2);
    check("t4_done_cyc2", done_cyc, 32'd15);
    check("t4_P_done2", p_done, 32'd36);
    check("t4_dec_cnt", dec_cnt, 32'd8);
    check("t4_overlap", overlap, 32'd0);
    $display("txn A=3 N=4 held: done@%0d P=%0d", done_cyc, p_done);

    // A=3, N=10, clr in cycle 4
    launch(16'd3, 16'd10);
    bus.start = 1'b0;
    run_to(4);
    check("t5_P_partial", bus.P, 32'd6);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("t5_P_clr", bus.P, 32'd0);
    check("t5_busy_clr", {31'd0, bus.busy}, 32'd0);
    check("t5_dec_clr", {31'd0, bus.dec_N}, 32'd0);
    run_to(20);
    check("t5_done_cnt", done_cnt, 32'd0);
    check("t5_ld_cnt", ld_cnt, 32'd1);
    check("t5_P_end", bus.P, 32'd0);
    $display("txn A=3 N=10 clr@4: done_cnt=%0d P=%0d", done_cnt, bus.P);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/repadd_mult_ctrl.md
# repadd_mult_ctrl

Controller and product accumulator for the repeated-addition multiplier. It sits directly downstream of the 16-bit load/decrement down-counter and closes the loop around it. It reads the counter value, drives the counter's load (`ld_N`) and decrement (`dec_N`) strobes, and adds the latched multiplicand A into a 32-bit product once per count. It exposes a start/busy/done handshake to the host-side sequencer.

## Interface
Parameters:
- `DATA_W`, 16: width of multiplicand A and of the counter value.
- `PROD_W`, 32: product width. Must equal 2*`DATA_W`.

Ports:
- `clk` in 1: single clock, rising edge.
- `clr` in 1: reset, synchronous, active-high. The same `clr` also drives the counter.
- `start` in 1: request a multiply. Sampled only in IDLE.
- `A` in `DATA_W`: multiplicand. Captured on the edge that accepts `start`.
- `cnt` in `DATA_W`: counter `dout`. The counter's `N` input is the multiplier, supplied by the host.
- `ld_N` out 1: counter load strobe.
- `dec_N` out 1: counter decrement strobe.
- `P` out `PROD_W`: product. Held stable from DONE until the next accepted start.
- `busy` out 1: high in LOAD, RUN and DONE.
- `done` out 1: one-cycle pulse when `P` is valid.

## Operation
- FSM states:
  - IDLE: `ld_N`=0, `dec_N`=0. If `start`=1: capture `a_reg<=A`, go to LOAD.
  - LOAD: `ld_N`=1. `P<=0`. Go to RUN.
  - RUN, `cnt`!=0: `dec_N`=1 (combinational from `cnt`), `P<=P+a_reg`, stay in RUN.
  - RUN, `cnt`==0: `dec_N`=0, `P` holds, go to DONE.
  - DONE: `done`=1, then go to IDLE unconditionally.
- `ld_N` and `dec_N` are never high together. Neither is high outside LOAD/RUN.
- Arithmetic:
  - `P+a_reg` is zero-extended to `PROD_W`.
  - The maximum result is 0xFFFF*0xFFFF = 0xFFFE0001, so no overflow is possible and no saturation logic exists.
- Boundary conditions:
  - N=0: RUN sees `cnt`=0 in its first cycle. Result `P`=0, no `dec_N` pulse.
  - `start` while busy, including in DONE: ignored, with no queuing.
  - `A` changing during a run: no effect, because `a_reg` is used.
  - `clr` together with `start`: `clr` wins.
  - `clr` mid-operation: on the next edge, state=IDLE, `P`=0, `a_reg`=0, `done`=0. Any partial result is discarded and no `done` pulse is issued.
- Reset values: state IDLE, `P`=0, `a_reg`=0, `busy`=0, `done`=0, `ld_N`=0, `dec_N`=0.

## Timing
- Cycle numbering: cycle 0 is the cycle in which `start` is sampled high in IDLE. Cycle k is the k-th cycle after it.
- Cycle 1: LOAD, `ld_N`=1. The counter holds N from cycle 2.
- Cycles 2..N+1: RUN with `dec_N`=1. Each iteration costs one cycle.
- Cycle N+2: RUN with `cnt`=0.
- Cycle N+3: DONE, `done`=1, `P`=A*N.
- Cycle N+4: IDLE. The earliest next `start` is sampled here.
- `busy` is high in cycles 1..N+3.
- Latency from start to `done` is N+3 cycles. For N=0 that is 3 cycles.
- `dec_N` depends combinationally on `cnt`, which is a registered counter output, so there is no combinational loop.

## Structure
- Shared package `mult_pkg` holds:
  - the `DATA_W` and `PROD_W` defaults;
  - the 2-bit state encoding: IDLE=0, LOAD=1, RUN=2, DONE=3.
- One sub-module, `prod_acc`: a `PROD_W`-bit register with synchronous clear (`clr` or LOAD), add (RUN with `cnt`!=0) and hold (all other cases). The FSM and the `a_reg` capture live in the top module.

## Test plan
The bench instantiates this block together with the down-counter.
- Reset: hold `clr` for 2 cycles with `start`=1 -> all outputs 0, no `ld_N`, state IDLE.
- A=7, N=5, `start` pulsed for 1 cycle -> `ld_N` in cycle 1, `dec_N` in cycles 2..6, `done` in cycle 8, `P`=35, `busy` low from cycle 9.
- A=0xFFFF, N=0 -> `done` in cycle 3, `P`=0, `dec_N` never asserted.
- A=0xFFFF, N=0xFFFF -> `done` in cycle 65538, `P`=0xFFFE0001.
- A=3, N=4 with `start` held high and A changed to 9 during RUN -> `P`=12, a single `done`. A new run starts only when `start` is sampled in IDLE at cycle 8.
- A=3, N=10, `clr` asserted in cycle 4 -> cycle 5 is IDLE with `P`=0, `busy`=0, and no `done` pulse ever.
